// File: rtl/usb_crc_pkg.sv
// Shared USB CRC16 constants and checker state encoding; reused by the transmit-side generator.
package usb_crc_pkg;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD1 = 2'd1,
    ST_HOLD2 = 2'd2,
    ST_RUN   = 2'd3
  } chk_state_e;

endpackage

// File: rtl/crc16_update.sv
// Combinational one-byte step of the reflected USB CRC16 (LSB first), no latency, no flow control.
module crc16_update
  import usb_crc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_w;

  always_comb begin
    crc_w = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      crc_w = crc_w[0] ? ((crc_w >> 1) ^ CRC16_POLY_REFL) : (crc_w >> 1);
    end
  end

  assign crc_out = crc_w;

endmodule

// File: rtl/crc16_chk.sv
// USB DATA-packet CRC16 checker/stripper: byte i leaves one cycle after byte i+2 is accepted; input stalls
// while the output register is full and not taken. Optional saturating err_cnt under CRC16_CHK_ERRCNT_EN.
module crc16_chk
  import usb_crc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       chk_on,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_crc_ok,
  output logic       crc_ok_pulse,
  output logic       crc_err_pulse,
  output logic       abort_pulse
`ifdef CRC16_CHK_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  chk_state_e  state_q;
  logic [7:0]  hold0_q, hold1_q;
  logic [15:0] crc_q, crc_d;
  logic        out_valid_q, out_sop_q, out_eop_q, out_crc_ok_q;
  logic [7:0]  out_data_q;
  logic        ok_pulse_q, err_pulse_q, abort_pulse_q;
  logic        accept;
  logic        crc_pass;

  crc16_update u_crc16_update (
    .crc_in  (crc_q),
    .data    (in_data),
    .crc_out (crc_d)
  );

  assign in_ready = chk_on & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign crc_pass = (crc_d == CRC16_RESIDUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold0_q       <= 8'h00;
      hold1_q       <= 8'h00;
      crc_q         <= CRC16_INIT;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_crc_ok_q  <= 1'b0;
      out_data_q    <= 8'h00;
      ok_pulse_q    <= 1'b0;
      err_pulse_q   <= 1'b0;
      abort_pulse_q <= 1'b0;
    end else begin
      ok_pulse_q    <= 1'b0;
      err_pulse_q   <= 1'b0;
      abort_pulse_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (!chk_on) begin
        if (state_q != ST_IDLE) begin
          abort_pulse_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      end else if (accept) begin
        if (in_sop && in_eop) begin
          // A one-byte packet is short; it also abandons whatever was in progress.
          err_pulse_q   <= 1'b1;
          abort_pulse_q <= (state_q != ST_IDLE);
          state_q       <= ST_IDLE;
        end else if (in_sop) begin
          abort_pulse_q <= (state_q != ST_IDLE);
          hold0_q       <= in_data;
          crc_q         <= CRC16_INIT;
          state_q       <= ST_HOLD1;
        end else begin
          case (state_q)
            ST_IDLE: begin
            end
            ST_HOLD1: begin
              if (in_eop) begin
                err_pulse_q <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                hold1_q <= in_data;
                crc_q   <= crc_d;
                state_q <= ST_HOLD2;
              end
            end
            ST_HOLD2, ST_RUN: begin
              // Releasing the oldest held byte keeps the two trailing CRC bytes out of the stream.
              out_valid_q  <= 1'b1;
              out_data_q   <= hold0_q;
              out_sop_q    <= (state_q == ST_HOLD2);
              out_eop_q    <= in_eop;
              out_crc_ok_q <= in_eop & crc_pass;
              hold0_q      <= hold1_q;
              hold1_q      <= in_data;
              crc_q        <= crc_d;
              if (in_eop) begin
                ok_pulse_q  <= crc_pass;
                err_pulse_q <= ~crc_pass;
                state_q     <= ST_IDLE;
              end else begin
                state_q <= ST_RUN;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_sop       = out_sop_q;
  assign out_eop       = out_eop_q;
  assign out_data      = out_data_q;
  assign out_crc_ok    = out_crc_ok_q;
  assign crc_ok_pulse  = ok_pulse_q;
  assign crc_err_pulse = err_pulse_q;
  assign abort_pulse   = abort_pulse_q;

`ifdef CRC16_CHK_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else if (err_pulse_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_chk.sv
// Bench for crc16_chk: directed USB packets plus random traffic checked against a packet-level model.
module tb_crc16_chk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       chk_on = 1'b0;
  logic       in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_sop, out_eop, out_valid, out_crc_ok;
  logic       crc_ok_pulse, crc_err_pulse, abort_pulse;
  logic [7:0] out_data;
`ifdef CRC16_CHK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  crc16_chk dut (
`ifdef CRC16_CHK_ERRCNT_EN
    .err_cnt       (err_cnt),
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .chk_on        (chk_on),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_crc_ok    (out_crc_ok),
    .crc_ok_pulse  (crc_ok_pulse),
    .crc_err_pulse (crc_err_pulse),
    .abort_pulse   (abort_pulse)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] d; logic s; logic e; logic ok;} beat_t;

  beat_t outq[$];
  beat_t expq[$];
  int    rd_idx = 0;
  int    n_ok = 0, n_err = 0, n_abort = 0;
  int    e_ok = 0, e_err = 0, e_abort = 0;
  int    checks = 0, failures = 0;
  bit    rand_bp = 1'b0;

  // Observed beats and verdict pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) outq.push_back(beat_t'{out_data, out_sop, out_eop, out_crc_ok});
    if (crc_ok_pulse)  n_ok++;
    if (crc_err_pulse) n_err++;
    if (abort_pulse)   n_abort++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // USB CRC16 as transmitted: bitwise LFSR over the payload, final inversion.
  function automatic logic [15:0] crc_usb(input bq_t b);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (r[0] ^ b[i][k]) r = (r >> 1) ^ 16'hA001;
        else                r = r >> 1;
      end
    end
    return ~r;
  endfunction

  // Packet-level expectation: everything but the last two bytes is forwarded.
  task automatic model_seq(input bq_t b, input bit full);
    int   n;
    bq_t  pl;
    logic good;
    n = b.size();
    good = 1'b0;
    if (full && n < 3) begin
      e_err++;
    end else begin
      pl = {};
      for (int i = 1; i <= n - 3; i++) pl.push_back(b[i]);
      if (full) begin
        good = (crc_usb(pl) == {b[n-1], b[n-2]});
        if (good) e_ok++;
        else      e_err++;
      end
      for (int i = 0; i <= n - 3; i++)
        expq.push_back(beat_t'{b[i], (i == 0), (full && i == n - 3), (good && i == n - 3)});
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    logic acc;
    acc = 1'b0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    check("byte_accepted", acc, 1);
  endtask

  task automatic send_seq(input bq_t b, input bit with_eop);
    foreach (b[i]) send_byte(b[i], (i == 0), with_eop && (i == b.size() - 1));
  endtask

  task automatic compare_all(input string tag);
    int    nb;
    beat_t o, e;
    out_ready = 1'b1;
    for (int t = 0; t < 300 && (outq.size() - rd_idx) < expq.size(); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    nb = outq.size() - rd_idx;
    check({tag, "_nbeats"}, nb, expq.size());
    for (int i = 0; i < expq.size() && i < nb; i++) begin
      o = outq[rd_idx + i];
      e = expq[i];
      check({tag, "_beat"}, {o.d, o.s, o.e, o.ok & e.e}, {e.d, e.s, e.e, e.ok & e.e});
    end
    rd_idx = outq.size();
    expq.delete();
    check({tag, "_ok_pulses"}, n_ok, e_ok);
    check({tag, "_err_pulses"}, n_err, e_err);
    check({tag, "_abort_pulses"}, n_abort, e_abort);
`ifdef CRC16_CHK_ERRCNT_EN
    check({tag, "_err_cnt"}, err_cnt, (e_err > 255) ? 255 : e_err);
`endif
  endtask

  initial begin
    bq_t pkt1, pkt_bad, b;
    int  n, idx;
    logic [15:0] c;

    pkt1 = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    pkt_bad = pkt1;
    pkt_bad[11] = 8'hB5;

    chk_on = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {out_valid, out_sop, out_eop, out_crc_ok, crc_ok_pulse,
                            crc_err_pulse, abort_pulse, out_data}, 0);
`ifdef CRC16_CHK_ERRCNT_EN
    check("reset_err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_seq(pkt1, 1); model_seq(pkt1, 1);
    compare_all("good_pkt");

    b = '{8'hC3, 8'h00, 8'h00};
    send_seq(b, 1); model_seq(b, 1);
    compare_all("zero_len");

    send_seq(pkt_bad, 1); model_seq(pkt_bad, 1);
    compare_all("bad_crc");

    // Hold the output for three cycles mid-packet; input must stall with it.
    fork
      send_seq(pkt1, 1);
      begin
        repeat (6) @(posedge clk);
        #1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          @(posedge clk);
        end
        #1; out_ready = 1'b1;
      end
    join
    model_seq(pkt1, 1);
    compare_all("stall");

    b = '{8'hC3};
    send_seq(b, 1); model_seq(b, 1);
    b = '{8'hC3, 8'h11};
    send_seq(b, 1); model_seq(b, 1);
    compare_all("short");

    b = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34};
    send_seq(b, 0); model_seq(b, 0); e_abort++;
    send_seq(pkt1, 1); model_seq(pkt1, 1);
    compare_all("abort_sop");

    b = '{8'hC3, 8'h31, 8'h32};
    send_seq(b, 0); model_seq(b, 0); e_abort++;
    chk_on = 1'b0;
    @(negedge clk); check("chk_off_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); check("chk_off_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk_on = 1'b1;
    compare_all("chk_off");

    rand_bp = 1'b1;
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0, 1'b0);
      n = $urandom_range(1, 12);
      b = {};
      if (n < 3) begin
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      end else begin
        for (int i = 0; i < n - 3; i++) b.push_back(8'($urandom));
        c = crc_usb(b);
        b.push_front(8'hC3);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
        if ($urandom_range(0, 2) == 0) begin
          idx = $urandom_range(1, n - 1);
          b[idx] = b[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
      end
      send_seq(b, 1); model_seq(b, 1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_bp = 1'b0;
    compare_all("random");

    b = '{8'hC3, 8'h31, 8'h32, 8'h33};
    send_seq(b, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midpkt_reset_outputs", {out_valid, out_sop, out_eop, out_crc_ok, crc_ok_pulse,
                                   crc_err_pulse, abort_pulse, out_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_idx = outq.size();
    send_seq(pkt1, 1); model_seq(pkt1, 1);
    compare_all("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc16_chk.md
# crc16_chk

Receive-side USB DATA-packet CRC16 checker, directly downstream of the PHY-facing DATA-phase staging stage. Consumes the byte stream PID, payload, CRC-lo, CRC-hi. It computes CRC16 over payload plus CRC bytes and strips the two CRC bytes. It forwards PID and payload to the link layer, and reports pass/fail both on the final output beat and to `link_control`.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- chk_on  in  1  enable from `link_control`; DATA phase active
- in_sop / in_eop  in  1  first / last byte of packet (qualified by in_valid)
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid & in_ready
- in_data  in  8  input byte
- out_sop / out_eop  out  1  first (PID) / last forwarded byte
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  8  forwarded byte
- out_crc_ok  out  1  CRC result; meaningful only on out_valid & out_eop
- crc_ok_pulse / crc_err_pulse  out  1  one-cycle packet verdict to `link_control`
- abort_pulse  out  1  one-cycle: packet in progress abandoned
- err_cnt  out  8  saturating error count (only with CRC16_CHK_ERRCNT_EN)

## Operation
- CRC: reflected, polynomial 16'hA001, LSB-first, init 16'hFFFF. It covers every accepted byte after the PID, including both CRC bytes. Pass iff the register equals residue 16'hB001 after the eop byte.
- States: IDLE, HOLD1 (PID held), HOLD2 (PID + 1 byte held), RUN.
- IDLE: byte accepted with in_sop -> HOLD1, CRC reg <= 16'hFFFF. Non-sop bytes are accepted and dropped.
- HOLD1 -> HOLD2 on next accepted byte. HOLD2 -> RUN on next accepted byte.
- Release rule: input byte i goes to the output register when byte i+2 is accepted. out_eop = in_eop of byte i+2. out_sop = 1 for the PID. This withholds exactly the last two bytes (CRC).
- RUN: eop byte accepted -> release last payload byte with out_eop, compute verdict, -> IDLE.
- Zero-length packet (PID, CRC-lo, CRC-hi): PID is released with out_sop=out_eop=1.
- Short packet (eop on byte 0 or 1): nothing forwarded, crc_err_pulse, -> IDLE.
- in_sop accepted while not IDLE: abort_pulse, held bytes discarded, restart as HOLD1 with the new byte. Bytes already forwarded get no eop; `link_control` uses abort_pulse.
- chk_on low: in_ready=0. If not IDLE, abort_pulse and -> IDLE. The output register still drains.
- in_ready = chk_on & (~out_valid | out_ready). Always applied, including in HOLD states.
- Simultaneous in_sop & in_eop on one byte: short-packet rule.

## Timing
- Reset: state IDLE, CRC reg 16'hFFFF, held bytes 0, all outputs 0, err_cnt 0.
- Latency: byte i appears on out_* the cycle after byte i+2 is accepted.
- Verdict pulses and out_crc_ok are registered. They assert the cycle after the eop byte is accepted, the same cycle the eop beat first presents.
- Pulses are high exactly one cycle and independent of out_ready.
- out_valid/out_data/out_eop/out_crc_ok hold stable while out_valid & ~out_ready.
- Reset mid-packet: immediate return to reset values; no pulses.

## Configuration
- CRC16_CHK_ERRCNT_EN defined: err_cnt port present. It increments on each crc_err_pulse and saturates at 8'hFF; abort does not count.
- Not defined: err_cnt port and counter absent; all other behaviour identical.

## Structure
- Shared package usb_crc_pkg holds CRC16_POLY_REFL=16'hA001, CRC16_INIT=16'hFFFF, CRC16_RESIDUE=16'hB001, and the state enum for IDLE/HOLD1/HOLD2/RUN.
- One sub-module: crc16_update, a combinational next-CRC for one byte (crc_in[15:0], data[7:0] -> crc_out[15:0]). It is reusable by the transmit-side generator.

## Test plan
- PID C3, bytes 31..39, C8, B4(eop), out_ready=1 -> out C3(sop)..39(eop), out_crc_ok=1, crc_ok_pulse once.
- C3, 00, 00(eop) -> single beat C3 with sop=eop=1, out_crc_ok=1.
- Same as first with last byte B5 -> eop beat out_crc_ok=0, crc_err_pulse; err_cnt=1 with CRC16_CHK_ERRCNT_EN.
- First packet with out_ready low 3 cycles mid-stream -> in_ready low those cycles, output sequence identical, no loss or duplication.
- C3(sop+eop) alone, then C3, 11(eop) -> no output beats, two crc_err_pulse.
- sop mid-packet after 5 bytes, then valid packet -> abort_pulse once, second packet passes. Separately, rst_n low mid-packet -> all outputs 0 next edge.
